// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access widths, FSM states and default sizing.
package lsu_pkg;

   typedef enum logic [2:0] {
      MW_B  = 3'b000,
      MW_H  = 3'b001,
      MW_W  = 3'b010,
      MW_BU = 3'b100,
      MW_HU = 3'b101
   } mem_width_e;

   typedef enum logic {
      IDLE,
      RMW_WR
   } lsu_state_e;

   localparam int LSU_DEPTH_WORDS_DEFAULT = 512;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: extracts/extends load data and merges sub-word store
// data into a full word, both keyed by funct3 and the byte offset.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   input  logic [31:0] word_in,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [7:0]  byte_val;
   logic [15:0] half_val;
   logic [3:0]  lane_sel;

   assign byte_val = word_in[{byte_off, 3'b000} +: 8];
   assign half_val = byte_off[1] ? word_in[31:16] : word_in[15:0];

   always_comb begin
      load_data = 32'h0;
      case (funct3)
         MW_B:    load_data = {{24{byte_val[7]}}, byte_val};
         MW_BU:   load_data = {24'h0, byte_val};
         MW_H:    load_data = {{16{half_val[15]}}, half_val};
         MW_HU:   load_data = {16'h0, half_val};
         MW_W:    load_data = word_in;
         default: load_data = 32'h0;
      endcase
   end

   always_comb begin
      lane_sel = 4'b1111;
      case (funct3)
         MW_B:    lane_sel = 4'b0001 << byte_off;
         MW_H:    lane_sel = byte_off[1] ? 4'b1100 : 4'b0011;
         default: lane_sel = 4'b1111;
      endcase
   end

   // Each byte lane takes either the replicated store byte or the original memory byte.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] st_byte;
         always_comb begin
            st_byte = store_data[8*gi +: 8];
            case (funct3)
               MW_B:    st_byte = store_data[7:0];
               MW_H:    st_byte = store_data[8*(gi % 2) +: 8];
               default: st_byte = store_data[8*gi +: 8];
            endcase
         end
         assign merged_word[8*gi +: 8] = lane_sel[gi] ? st_byte : word_in[8*gi +: 8];
      end
   endgenerate

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store initiator for a word-wide data memory without byte enables; sub-word
// stores become a stalled read cycle followed by a merged-word write cycle.
module lsu_dmem_ctrl
   import lsu_pkg::*;
#(
   parameter int DEPTH_WORDS = LSU_DEPTH_WORDS_DEFAULT,
   parameter int AW          = 30
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   input  logic          req_we,
   input  logic [2:0]    req_funct3,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_wdata,
   output logic [31:0]   rdata,
   output logic          stall,
   output logic          fault,
   output logic [AW-1:0] dmem_addr,
   output logic [31:0]   dmem_wdata,
   output logic          dmem_we,
   output logic          dmem_re,
   input  logic [31:0]   dmem_rdata
);

   localparam int IW = $clog2(DEPTH_WORDS);

   lsu_state_e    state_reg, state_next;
   logic [IW-1:0] addr_reg, addr_next;
   logic [31:0]   merged_reg, merged_next;

   logic        illegal;
   logic        misaligned;
   logic        out_of_range;
   logic        bad_req;
   logic        sub_word;
   logic [31:0] load_data;
   logic [31:0] merged_word;

   always_comb begin
      illegal = 1'b1;
      case (req_funct3)
         MW_B, MW_H, MW_W, MW_BU, MW_HU: illegal = 1'b0;
         default:                        illegal = 1'b1;
      endcase
   end

   assign misaligned   = (((req_funct3 == MW_H) || (req_funct3 == MW_HU)) && req_addr[0])
                       || ((req_funct3 == MW_W) && (req_addr[1:0] != 2'b00));
   assign out_of_range = {2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS);
   assign bad_req      = illegal || misaligned || out_of_range;
   assign sub_word     = (req_funct3 == MW_B) || (req_funct3 == MW_H);

   lsu_lane_align u_align (
      .funct3      (req_funct3),
      .byte_off    (req_addr[1:0]),
      .word_in     (dmem_rdata),
      .store_data  (req_wdata),
      .load_data   (load_data),
      .merged_word (merged_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         addr_reg   <= '0;
         merged_reg <= '0;
      end else begin
         state_reg  <= state_next;
         addr_reg   <= addr_next;
         merged_reg <= merged_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      addr_next   = addr_reg;
      merged_next = merged_reg;
      case (state_reg)
         IDLE: begin
            if (req_valid && !bad_req && req_we && sub_word) begin
               state_next  = RMW_WR;
               addr_next   = req_addr[IW+1:2];
               merged_next = merged_word;
            end
         end
         RMW_WR:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Reset masks every strobe, including a pending RMW write.
   always_comb begin
      rdata      = 32'h0;
      stall      = 1'b0;
      fault      = 1'b0;
      dmem_we    = 1'b0;
      dmem_re    = 1'b0;
      dmem_addr  = req_addr[AW+1:2];
      dmem_wdata = req_wdata;
      if (!rst) begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  if (bad_req) begin
                     fault = 1'b1;
                  end else if (!req_we) begin
                     dmem_re = 1'b1;
                     rdata   = load_data;
                  end else if (sub_word) begin
                     dmem_re = 1'b1;
                     stall   = 1'b1;
                  end else begin
                     dmem_we = 1'b1;
                  end
               end
            end
            RMW_WR: begin
               dmem_addr  = AW'(addr_reg);
               dmem_wdata = merged_reg;
               dmem_we    = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Self-checking bench: behavioural word memory, write scoreboard checked at the
// memory commit edge, and per-scenario tasks with inline comparisons.
module tb_lsu_dmem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        fault;
   logic [29:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_we;
   logic        dmem_re;
   logic [31:0] dmem_rdata;

   logic [31:0] mem [512];

   typedef struct {
      logic [29:0] addr;
      logic [31:0] data;
   } wr_t;
   wr_t wr_q[$];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lsu_dmem_ctrl #(.DEPTH_WORDS(512), .AW(30)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rdata      (rdata),
      .stall      (stall),
      .fault      (fault),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_we    (dmem_we),
      .dmem_re    (dmem_re),
      .dmem_rdata (dmem_rdata)
   );

   always_comb begin
      dmem_rdata = 32'h0;
      if (dmem_addr < 30'd512) dmem_rdata = mem[dmem_addr[8:0]];
   end

   // Memory commits on negedge; every write must match the next scoreboard entry.
   always @(negedge clk) begin
      if (dmem_we) begin
         total++;
         if (wr_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got addr=%0h data=%08h, required no write", dmem_addr, dmem_wdata);
         end else begin
            wr_t exp_w;
            exp_w = wr_q.pop_front();
            if (dmem_addr !== exp_w.addr || dmem_wdata !== exp_w.data) begin
               bad++;
               $display("FAIL write_data: got addr=%0h data=%08h, required addr=%0h data=%08h",
                        dmem_addr, dmem_wdata, exp_w.addr, exp_w.data);
            end
         end
         if (dmem_addr < 30'd512) mem[dmem_addr[8:0]] = dmem_wdata;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
      req_valid  = v;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      $display("txn t=%0t valid=%0b we=%0b f3=%03b addr=%08h wdata=%08h", $time, v, we, f3, a, wd);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 1'b1, 3'b010, 32'h20, 32'h1234_5678);
      step();
      step();
      #2;
      total++;
      if (stall !== 1'b0 || fault !== 1'b0 || dmem_we !== 1'b0 || dmem_re !== 1'b0 || rdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_outputs: got stall=%b fault=%b we=%b re=%b rdata=%08h, required all 0",
                  stall, fault, dmem_we, dmem_re, rdata);
      end
      step();
      rst = 1'b0;
      drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
   endtask

   task automatic test_loads();
      logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001};
      logic [31:0] adrs [5] = '{32'h17, 32'h17, 32'h14, 32'h16, 32'h16};
      logic [31:0] exps [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_7F22, 32'h0000_80F1, 32'hFFFF_80F1};
      mem[5] = 32'h80F1_7F22;
      for (int i = 0; i < 5; i++) begin
         step();
         drive(1'b1, 1'b0, f3s[i], adrs[i], 32'h0);
         #2;
         total++;
         if (rdata !== exps[i] || stall !== 1'b0 || dmem_we !== 1'b0 || dmem_re !== 1'b1) begin
            bad++;
            $display("FAIL load_%0d: got rdata=%08h stall=%b we=%b re=%b, required rdata=%08h stall=0 we=0 re=1",
                     i, rdata, stall, dmem_we, dmem_re, exps[i]);
         end
      end
   endtask

   task automatic test_store_word();
      step();
      drive(1'b1, 1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF);
      wr_q.push_back('{addr: 30'd8, data: 32'hDEAD_BEEF});
      #2;
      total++;
      if (dmem_we !== 1'b1 || dmem_addr !== 30'd8 || stall !== 1'b0) begin
         bad++;
         $display("FAIL sw_cycle: got we=%b addr=%0h stall=%b, required we=1 addr=8 stall=0", dmem_we, dmem_addr, stall);
      end
      step();
      drive(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
      #2;
      total++;
      if (rdata !== 32'hDEAD_BEEF || dmem_we !== 1'b0) begin
         bad++;
         $display("FAIL sw_readback: got rdata=%08h we=%b, required rdata=deadbeef we=0", rdata, dmem_we);
      end
   endtask

   task automatic sub_store(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp_word);
      step();
      mem[5] = 32'h1122_3344;
      drive(1'b1, 1'b1, f3, a, wd);
      #2;
      total++;
      if (stall !== 1'b1 || dmem_we !== 1'b0 || dmem_re !== 1'b1 || fault !== 1'b0) begin
         bad++;
         $display("FAIL %s_c1: got stall=%b we=%b re=%b fault=%b, required stall=1 we=0 re=1 fault=0",
                  name, stall, dmem_we, dmem_re, fault);
      end
      wr_q.push_back('{addr: 30'd5, data: exp_word});
      step();
      #2;
      total++;
      if (dmem_we !== 1'b1 || dmem_wdata !== exp_word || dmem_addr !== 30'd5 || stall !== 1'b0
          || rdata !== 32'h0 || fault !== 1'b0) begin
         bad++;
         $display("FAIL %s_c2: got we=%b wdata=%08h addr=%0h stall=%b rdata=%08h fault=%b, required we=1 wdata=%08h addr=5 stall=0 rdata=0 fault=0",
                  name, dmem_we, dmem_wdata, dmem_addr, stall, rdata, fault, exp_word);
      end
      step();
      drive(1'b1, 1'b0, 3'b010, 32'h14, 32'h0);
      #2;
      total++;
      if (rdata !== exp_word || stall !== 1'b0 || dmem_we !== 1'b0) begin
         bad++;
         $display("FAIL %s_readback: got rdata=%08h stall=%b we=%b, required rdata=%08h stall=0 we=0",
                  name, rdata, stall, dmem_we, exp_word);
      end
   endtask

   task automatic test_sb();
      sub_store("sb", 3'b000, 32'h15, 32'h0000_00AA, 32'h1122_AA44);
   endtask

   task automatic test_sh();
      sub_store("sh", 3'b001, 32'h16, 32'h0000_BEEF, 32'hBEEF_3344);
   endtask

   task automatic test_faults();
      logic        wes  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [2:0]  f3s  [4] = '{3'b010, 3'b001, 3'b010, 3'b011};
      logic [31:0] adrs [4] = '{32'h22, 32'h13, 32'h800, 32'h14};
      for (int i = 0; i < 4; i++) begin
         step();
         drive(1'b1, wes[i], f3s[i], adrs[i], 32'hFFFF_FFFF);
         #2;
         total++;
         if (fault !== 1'b1 || dmem_we !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0) begin
            bad++;
            $display("FAIL fault_%0d: got fault=%b we=%b stall=%b rdata=%08h, required fault=1 we=0 stall=0 rdata=0",
                     i, fault, dmem_we, stall, rdata);
         end
      end
      step();
      drive(1'b0, 1'b1, 3'b010, 32'h14, 32'h0);
      #2;
      total++;
      if (dmem_we !== 1'b0 || dmem_re !== 1'b0 || rdata !== 32'h0 || dmem_addr !== 30'd5) begin
         bad++;
         $display("FAIL idle_novalid: got we=%b re=%b rdata=%08h addr=%0h, required we=0 re=0 rdata=0 addr=5",
                  dmem_we, dmem_re, rdata, dmem_addr);
      end
   endtask

   task automatic test_reset_rmw();
      step();
      mem[5] = 32'h1122_3344;
      drive(1'b1, 1'b1, 3'b000, 32'h15, 32'h0000_00AA);
      #2;
      total++;
      if (stall !== 1'b1) begin
         bad++;
         $display("FAIL rstrmw_c1: got stall=%b, required stall=1", stall);
      end
      step();
      rst = 1'b1;
      #2;
      total++;
      if (dmem_we !== 1'b0 || stall !== 1'b0) begin
         bad++;
         $display("FAIL rstrmw_c2: got we=%b stall=%b, required we=0 stall=0", dmem_we, stall);
      end
      step();
      rst = 1'b0;
      drive(1'b0, 1'b0, 3'b010, 32'h14, 32'h0);
      #2;
      total++;
      if (stall !== 1'b0 || mem[5] !== 32'h1122_3344) begin
         bad++;
         $display("FAIL rstrmw_after: got stall=%b word5=%08h, required stall=0 word5=11223344", stall, mem[5]);
      end
      step();
      drive(1'b1, 1'b0, 3'b010, 32'h14, 32'h0);
      #2;
      total++;
      if (rdata !== 32'h1122_3344 || stall !== 1'b0 || dmem_we !== 1'b0) begin
         bad++;
         $display("FAIL rstrmw_idle: got rdata=%08h stall=%b we=%b, required rdata=11223344 stall=0 we=0",
                  rdata, stall, dmem_we);
      end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 32'h0;
      rst = 1'b1;
      drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
      test_reset();
      test_loads();
      test_store_word();
      test_sb();
      test_sh();
      test_faults();
      test_reset_rmw();
      step();
      drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
      step();
      total++;
      if (wr_q.size() != 0) begin
         bad++;
         $display("FAIL pending_writes: got %0d outstanding, required 0", wr_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu_dmem_ctrl.md
Name: lsu_dmem_ctrl

Overview:
- Load/store initiator that drives the word-wide data memory from the execute/memory stage of the 3-stage pipeline.
- Translates RV32I byte/half/word loads and stores into word accesses.
- The data memory has a single word write enable and no byte mask. Sub-word stores are therefore done as a two-cycle read-modify-write, and the pipeline is stalled for the first of those cycles.
- Also handles load extraction, sign/zero extension, and misalignment and range faults.

Parameters:
- DEPTH_WORDS, 512, number of 32-bit words in the data memory; word index width is $clog2(DEPTH_WORDS).
- AW, 30, width of the word address driven to the data memory.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  memory operation present this cycle.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rdata  out  32  extended load result, valid same cycle.
- stall  out  1  hold the pipeline; request inputs must stay stable.
- fault  out  1  misaligned, out-of-range, or illegal funct3; operation suppressed.
- dmem_addr  out  AW  word address, req_addr[31:2] or latched address.
- dmem_wdata  out  32  word to write.
- dmem_we  out  1  write strobe; the memory commits on the following negedge.
- dmem_re  out  1  read enable, informational.
- dmem_rdata  in  32  asynchronous read data from memory.

Behaviour:
- Reset: state=IDLE; latched addr/data regs=0. While rst=1: stall=0, fault=0, dmem_we=0, dmem_re=0, rdata=0.
- FSM states: IDLE and RMW_WR.
- Legality (combinational, IDLE only):
  - misaligned = (H/HU and addr[0]) or (W and addr[1:0]!=0).
  - out of range = req_addr[31:2] >= DEPTH_WORDS.
  - illegal = funct3 not in {000,001,010,100,101}.
  - Any of these with req_valid gives fault=1, dmem_we=0, rdata=0, no state change.
- Load, IDLE, legal:
  - dmem_re=1.
  - Lane select uses addr[1:0]: B/BU byte lane addr[1:0], H/HU half lane addr[1].
  - B and H sign-extend; BU and HU zero-extend.
  - Zero-cycle latency, combinational from dmem_rdata; stall=0.
- Word store, IDLE, legal: dmem_we=1, dmem_wdata=req_wdata, single cycle, stall=0.
- Sub-word store (SB/SH), IDLE, legal:
  - Cycle 1: dmem_re=1, dmem_we=0, stall=1.
  - Cycle 1 captures the merged word: dmem_rdata with the target lane replaced by req_wdata[7:0] or [15:0]. It also latches the word address. Next state is RMW_WR.
  - Cycle 2 (RMW_WR): dmem_addr=latched address, dmem_wdata=merged word, dmem_we=1, stall=0. Request inputs are ignored. Next state is IDLE.
- Pipeline interaction: a request held through the stall is seen again in RMW_WR and ignored. The pipeline advances after cycle 2, so each store is performed exactly once.
- Outputs in RMW_WR: rdata=0 and fault=0.
- req_valid=0: all strobes 0, rdata=0, dmem_addr still follows req_addr.
- Reset asserted in RMW_WR: no write occurs that cycle (dmem_we forced 0 while rst=1) and state returns to IDLE.
- No back-to-back hazard: the RMW read and write target the same word, and the memory write lands on the negedge of cycle 2, before any following load.

Decomposition:
- Shared package lsu_pkg holds:
  - enum mem_width_e {MW_B=3'b000, MW_H=3'b001, MW_W=3'b010, MW_BU=3'b100, MW_HU=3'b101}.
  - enum lsu_state_e {IDLE, RMW_WR}.
  - Localparam for the default DEPTH_WORDS.
- One natural sub-module, lsu_lane_align: combinational load extract/extend and store merge, keyed by funct3 and addr[1:0]. Used for both paths.

Test Plan:
- Memory word 5 preloaded with 0x80F1_7F22; LB addr=0x17 -> rdata=0xFFFF_FF80, stall=0. LBU addr=0x17 -> 0x0000_0080. LH addr=0x14 -> 0x0000_7F22.
- SW 0xDEAD_BEEF to 0x20 -> dmem_we=1 for one cycle, dmem_addr=8, stall=0. Then LW 0x20 -> 0xDEAD_BEEF.
- Word 5=0x1122_3344; SB 0xAA to 0x15:
  - Cycle 1: stall=1, we=0.
  - Cycle 2: we=1, wdata=0x1122_AA44.
  - Following LW 0x14 -> 0x1122_AA44.
- SH to 0x16 with wdata 0x0000_BEEF on word 0x1122_3344 -> write 0xBEEF_3344, two cycles total.
- Faults, each with no dmem_we and stall=0:
  - LW addr=0x22 -> fault=1.
  - SH addr=0x13 -> fault=1.
  - SW addr=0x800 with DEPTH 512 -> fault=1.
  - funct3=011 -> fault=1.
- SB accepted, rst=1 during the RMW_WR cycle -> no write; memory word unchanged; state IDLE; stall=0 after reset.
